// File: rtl/ibexc_dmem_responder_if.sv
// Core data-memory bus (33-bit data with a capability tag in bit 32).
// The master modport is the core side; the slave modport is the responder side.
interface ibexc_dmem_responder_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic        data_is_cap;
  logic [32:0] data_wdata;
  logic        data_rvalid;
  logic [32:0] data_rdata;
  logic [6:0]  data_rdata_intg;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_is_cap, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_is_cap, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );
endinterface

// File: rtl/ibexc_dmem_responder.sv
// Data-memory responder: word array plus capability tags, fixed-latency in-order
// responses, outstanding-request throttling and an injectable bus-error window.
module ibexc_dmem_responder #(
  parameter int unsigned MemDepthW      = 12,
  parameter logic [31:0] BaseAddr       = 32'h2000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] ErrBase        = 32'h2000_3F00,
  parameter logic [31:0] ErrSize        = 32'h100
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  ibexc_dmem_responder_if.slave         dmem,
  input  logic                          stall_i,
  output logic [2:0]                    outstanding_o
);

  localparam int unsigned Depth  = 2 ** MemDepthW;
  localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] off;
    logic        oob;
    logic        win;
    off = addr - BaseAddr;
    oob = |off[31:MemDepthW+2];
    win = (ErrSize != 32'd0) && (addr >= ErrBase) && ((addr - ErrBase) < ErrSize);
    return oob | win;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Only a full-word capability store may set the tag; any other store clears it.
  function automatic logic next_tag(input logic       is_cap,
                                    input logic [3:0] be,
                                    input logic       wtag);
    return is_cap && (be == 4'hF) && wtag;
  endfunction

  logic [31:0]          mem_q [Depth];
  logic [Depth-1:0]     tag_q;
  logic [2:0]           outstanding_q, outstanding_d;

  logic [Latency-1:0]   rsp_vld_q, rsp_vld_d;
  logic [Latency-1:0]   rsp_err_q;
  logic [32:0]          rsp_data_q [Latency];

  logic                 gnt_p0;
  logic                 acc_p0;
  logic                 err_p0;
  logic                 wr_en_p0;
  logic [31:0]          off_p0;
  logic [MemDepthW-1:0] idx_p0;
  logic [31:0]          rd_word_p0;
  logic                 rd_tag_p0;
  logic [32:0]          rsp_data_p0;
  logic                 rsp_vld_out;

  // ---- acceptance stage: grant, decode, array access ----
  assign gnt_p0     = dmem.data_req & ~stall_i & (outstanding_q < MaxOut);
  assign acc_p0     = dmem.data_req & gnt_p0;
  assign off_p0     = dmem.data_addr - BaseAddr;
  assign idx_p0     = off_p0[MemDepthW+1:2];
  assign err_p0     = addr_err(dmem.data_addr);
  assign wr_en_p0   = acc_p0 & dmem.data_we & ~err_p0;
  assign rd_word_p0 = mem_q[idx_p0];
  assign rd_tag_p0  = tag_q[idx_p0] & dmem.data_is_cap;

  always_comb begin
    rsp_data_p0 = '0;
    if (!dmem.data_we && !err_p0) rsp_data_p0 = {rd_tag_p0, rd_word_p0};
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_p0) begin
      mem_q[idx_p0] <= merge_bytes(mem_q[idx_p0], dmem.data_wdata[31:0], dmem.data_be);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else if (wr_en_p0 && (dmem.data_be != 4'h0)) begin
      tag_q[idx_p0] <= next_tag(dmem.data_is_cap, dmem.data_be, dmem.data_wdata[32]);
    end
  end

  // ---- response shift line: stage 0 .. Latency-1 ----
  always_comb begin
    rsp_vld_d    = '0;
    rsp_vld_d[0] = acc_p0;
    for (int i = 1; i < int'(Latency); i++) begin
      rsp_vld_d[i] = rsp_vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // Payload stages carry no reset; they are only observed through the valid bit.
  always_ff @(posedge clk_i) begin
    rsp_data_q[0] <= rsp_data_p0;
    rsp_err_q[0]  <= err_p0;
    for (int i = 1; i < int'(Latency); i++) begin
      rsp_data_q[i] <= rsp_data_q[i-1];
      rsp_err_q[i]  <= rsp_err_q[i-1];
    end
  end

  // ---- outstanding counter ----
  assign rsp_vld_out   = rsp_vld_q[Latency-1];
  assign outstanding_d = outstanding_q + {2'b00, acc_p0} - {2'b00, rsp_vld_out};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= 3'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign dmem.data_gnt        = gnt_p0;
  assign dmem.data_rvalid     = rsp_vld_out;
  assign dmem.data_rdata      = rsp_vld_out ? rsp_data_q[Latency-1] : 33'd0;
  assign dmem.data_err        = rsp_vld_out & rsp_err_q[Latency-1];
  assign dmem.data_rdata_intg = 7'd0;
  assign outstanding_o        = outstanding_q;

endmodule

// File: tb/tb_ibexc_dmem_responder.sv
// Bench for ibexc_dmem_responder: two instances (Latency 1 and 2), one active at a
// time, scored every cycle against a transaction-level memory/response model.
module tb_ibexc_dmem_responder;

  localparam logic [31:0] BASE     = 32'h2000_0000;
  localparam logic [31:0] ERR_BASE = 32'h2000_3F00;
  localparam logic [31:0] ERR_SIZE = 32'h100;
  localparam int          MAXO     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, req, we, is_cap, stall;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata;
  logic [2:0]  out1, out2;

  ibexc_dmem_responder_if bus1 ();
  ibexc_dmem_responder_if bus2 ();

  assign bus1.data_req    = req & ~sel;
  assign bus2.data_req    = req & sel;
  assign bus1.data_we     = we;
  assign bus2.data_we     = we;
  assign bus1.data_be     = be;
  assign bus2.data_be     = be;
  assign bus1.data_addr   = addr;
  assign bus2.data_addr   = addr;
  assign bus1.data_is_cap = is_cap;
  assign bus2.data_is_cap = is_cap;
  assign bus1.data_wdata  = wdata;
  assign bus2.data_wdata  = wdata;

  ibexc_dmem_responder #(.Latency(1), .MaxOutstanding(MAXO)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .dmem(bus1), .stall_i(stall & ~sel), .outstanding_o(out1));
  ibexc_dmem_responder #(.Latency(2), .MaxOutstanding(MAXO)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .dmem(bus2), .stall_i(stall & sel), .outstanding_o(out2));

  logic        obs_gnt, obs_rvalid, obs_err;
  logic [32:0] obs_rdata;
  logic [6:0]  obs_intg;
  logic [2:0]  obs_out;
  assign obs_gnt    = sel ? bus2.data_gnt        : bus1.data_gnt;
  assign obs_rvalid = sel ? bus2.data_rvalid     : bus1.data_rvalid;
  assign obs_err    = sel ? bus2.data_err        : bus1.data_err;
  assign obs_rdata  = sel ? bus2.data_rdata      : bus1.data_rdata;
  assign obs_intg   = sel ? bus2.data_rdata_intg : bus1.data_rdata_intg;
  assign obs_out    = sel ? out2 : out1;

  typedef struct {
    int          due;
    logic [32:0] rd;
    logic        er;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] m_data [2][4096];
  logic        m_tag  [2][4096];
  int          n_vec = 0, n_err = 0, cyc = 0, ocnt = 0;
  logic        gnt_seen = 1'b0;
  logic [32:0] last_rd = '0;
  logic        last_err = 1'b0;
  int          last_rv_cyc = -1, last_gnt_cyc = -1;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat();
    return sel ? 2 : 1;
  endfunction

  // Reference: apply a granted request to the memory image and queue its response.
  task automatic model_accept();
    logic [31:0] off;
    logic        e;
    int          idx, d;
    rsp_t        r;
    d   = sel ? 1 : 0;
    off = addr - BASE;
    e   = (off >= 32'h4000) || (addr >= ERR_BASE && addr < ERR_BASE + ERR_SIZE);
    idx = int'(off[13:2]);
    r.due = cyc + lat();
    r.rd  = '0;
    r.er  = e;
    if (!e) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_data[d][idx][8*b +: 8] = wdata[8*b +: 8];
        if (is_cap && be == 4'hF) m_tag[d][idx] = wdata[32];
        else if (be != 4'h0)      m_tag[d][idx] = 1'b0;
      end else begin
        r.rd = {m_tag[d][idx] & is_cap, m_data[d][idx]};
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic check_cycle();
    logic eg, erv;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      ocnt = 0;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4096; i++) m_tag[d][i] = 1'b0;
      chk("rst_rvalid", 40'(obs_rvalid), 40'(0));
      chk("rst_rdata", 40'(obs_rdata), 40'(0));
      chk("rst_err", 40'(obs_err), 40'(0));
      chk("rst_outstanding", 40'(obs_out), 40'(0));
      chk("rst_gnt", 40'(obs_gnt), 40'(req && !stall));
      gnt_seen = 1'b0;
      return;
    end
    erv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("rvalid", 40'(obs_rvalid), 40'(erv));
    if (erv) begin
      chk("rdata", 40'(obs_rdata), 40'(exp_q[0].rd));
      chk("err", 40'(obs_err), 40'(exp_q[0].er));
    end
    chk("outstanding", 40'(obs_out), 40'(ocnt));
    chk("intg", 40'(obs_intg), 40'(0));
    eg = req && !stall && (ocnt < MAXO);
    chk("gnt", 40'(obs_gnt), 40'(eg));
    if (obs_rvalid) begin
      last_rd     = obs_rdata;
      last_err    = obs_err;
      last_rv_cyc = cyc;
    end
    if (erv) begin
      void'(exp_q.pop_front());
      ocnt--;
    end
    if (eg) begin
      model_accept();
      ocnt++;
      last_gnt_cyc = cyc;
    end
    gnt_seen = eg;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request (held while stalled/throttled) until it is granted; req stays high.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic c, input logic [32:0] wd, input int nstall);
    we = w; addr = a; be = b; is_cap = c; wdata = wd; req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      stall = (k < nstall);
      step();
      if (gnt_seen) begin
        stall = 1'b0;
        return;
      end
    end
    stall = 1'b0;
    chk("issue_gnt", 40'(gnt_seen), 40'(1));
  endtask

  task automatic drain();
    req = 1'b0;
    for (int k = 0; k < 20 && (ocnt != 0 || exp_q.size() != 0); k++) step();
    step();
    chk("drain_outstanding", 40'(ocnt), 40'(0));
  endtask

  task automatic prewrite();
    for (int i = 0; i < 16; i++)
      issue(1'b1, BASE + 32'(4 * i), 4'hF, 1'($urandom_range(0, 1)),
            {1'($urandom_range(0, 1)), 32'($urandom)}, 0);
    drain();
  endtask

  task automatic random_phase(input int n);
    logic [31:0] a;
    int          r;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 11);
      if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = ERR_BASE + 32'($urandom_range(0, 255));
      else if (r == 9) a = 32'h2000_4000 + 32'(4 * $urandom_range(0, 255));
      else if (r == 10) a = 32'h1FFF_FFFC;
      else             a = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        step();
      end
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), 1'($urandom_range(0, 1)),
            {1'($urandom_range(0, 1)), 32'($urandom)},
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain();
  endtask

  initial begin
    int c0, ga, gb, gc, rv0;
    rst_n = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0; is_cap = 1'b0; stall = 1'b0;
    be = 4'h0; addr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // Latency-1 instance: basic write then read-after-write
    issue(1'b1, 32'h2000_0010, 4'hF, 1'b0, 33'h0_DEADBEEF, 0);
    issue(1'b0, 32'h2000_0010, 4'hF, 1'b0, 33'h0, 0);
    drain();
    chk("basic_rdata", 40'(last_rd), 40'(33'h0_DEADBEEF));
    chk("basic_err", 40'(last_err), 40'(0));
    chk("basic_latency", 40'(last_rv_cyc - last_gnt_cyc), 40'(1));

    // Tag semantics
    issue(1'b1, 32'h2000_0020, 4'hF, 1'b1, 33'h1_12345678, 0);
    issue(1'b0, 32'h2000_0020, 4'hF, 1'b1, 33'h0, 0);
    drain();
    chk("tag_cap_read", 40'(last_rd), 40'(33'h1_12345678));
    issue(1'b0, 32'h2000_0020, 4'hF, 1'b0, 33'h0, 0);
    drain();
    chk("tag_noncap_read", 40'(last_rd), 40'(33'h0_12345678));
    issue(1'b1, 32'h2000_0020, 4'h1, 1'b0, 33'h1_000000AB, 0);
    issue(1'b0, 32'h2000_0020, 4'hF, 1'b1, 33'h0, 0);
    drain();
    chk("tag_byte_write", 40'(last_rd), 40'(33'h0_123456AB));

    // Error window, out-of-range write, below-base read
    issue(1'b0, 32'h2000_3F04, 4'hF, 1'b0, 33'h0, 0);
    drain();
    chk("errwin_err", 40'(last_err), 40'(1));
    chk("errwin_rdata", 40'(last_rd), 40'(0));
    issue(1'b1, 32'h2000_0000, 4'hF, 1'b1, 33'h1_55AA55AA, 0);
    issue(1'b1, 32'h2000_4000, 4'hF, 1'b1, 33'h1_CAFEF00D, 0);
    drain();
    chk("oob_write_err", 40'(last_err), 40'(1));
    issue(1'b0, 32'h2000_0000, 4'hF, 1'b1, 33'h0, 0);
    drain();
    chk("oob_write_no_alias", 40'(last_rd), 40'(33'h1_55AA55AA));
    issue(1'b0, 32'h1FFF_FFFC, 4'hF, 1'b0, 33'h0, 0);
    drain();
    chk("below_base_err", 40'(last_err), 40'(1));

    // Stall for 3 cycles with req held
    c0 = cyc + 1;
    issue(1'b0, 32'h2000_0010, 4'hF, 1'b0, 33'h0, 3);
    chk("stall_grant_cycle", 40'(last_gnt_cyc), 40'(c0 + 3));
    drain();
    chk("stall_latency", 40'(last_rv_cyc - last_gnt_cyc), 40'(1));
    chk("stall_rdata", 40'(last_rd), 40'(33'h0_DEADBEEF));

    random_phase(250);

    // Latency-2 instance
    sel = 1'b1;
    step();
    prewrite();

    // Back-to-back reads against a full outstanding window
    issue(1'b0, 32'h2000_0004, 4'hF, 1'b0, 33'h0, 0);
    ga = last_gnt_cyc;
    issue(1'b0, 32'h2000_0008, 4'hF, 1'b1, 33'h0, 0);
    gb = last_gnt_cyc;
    issue(1'b0, 32'h2000_000C, 4'hF, 1'b0, 33'h0, 0);
    gc = last_gnt_cyc;
    chk("pipe_second_grant", 40'(gb), 40'(ga + 1));
    chk("pipe_third_grant", 40'(gc), 40'(ga + 3));
    drain();

    // Reset one cycle after a read grant discards the response and clears tags
    issue(1'b1, 32'h2000_0030, 4'hF, 1'b1, 33'h1_0BADCAFE, 0);
    drain();
    issue(1'b0, 32'h2000_0030, 4'hF, 1'b1, 33'h0, 0);
    rv0 = last_rv_cyc;
    req = 1'b0;
    rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("rst_mid_no_rvalid", 40'(last_rv_cyc), 40'(rv0));
    chk("rst_mid_outstanding", 40'(obs_out), 40'(0));
    issue(1'b0, 32'h2000_0030, 4'hF, 1'b1, 33'h0, 0);
    drain();
    chk("rst_mid_tag_cleared", 40'(last_rd), 40'(33'h0_0BADCAFE));

    random_phase(250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
